// File: rtl/systolic_pkg.sv
// Shared types and helper functions for the output-stationary systolic tile.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int acc_width(input int bit_width, input int acc_guard);
    return 2 * bit_width + acc_guard;
  endfunction

  // Half an LSB of the output format, so the shift rounds half up.
  function automatic longint round_const(input int frac_width);
    if (frac_width > 0) begin
      return 64'sd1 <<< (frac_width - 1);
    end else begin
      return 64'sd0;
    end
  endfunction

  function automatic longint sat_max(input int bit_width);
    return (64'sd1 <<< (bit_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int bit_width);
    return -(64'sd1 <<< (bit_width - 1));
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Multiply-accumulate cell: forwards A east and B south, accumulates a*b.
module systolic_pe #(
  parameter int BIT_WIDTH = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic                        i_clr,
  input  logic signed [BIT_WIDTH-1:0] i_a,
  input  logic signed [BIT_WIDTH-1:0] i_b,
  output logic signed [BIT_WIDTH-1:0] o_a,
  output logic signed [BIT_WIDTH-1:0] o_b,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  logic signed [BIT_WIDTH-1:0]   r_a;
  logic signed [BIT_WIDTH-1:0]   r_b;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [2*BIT_WIDTH-1:0] w_prod;

  assign w_prod = i_a * i_b;

  // Operand forwarding and accumulation; clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_a <= i_a;
      r_b <= i_b;
      if (i_clr) begin
        r_acc <= '0;
      end else begin
        r_acc <= r_acc + ACC_WIDTH'(w_prod);
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_tile.sv
// Output-stationary ROWSxCOLS systolic matmul tile with internal skew and row-wise drain.
// SYSTOLIC_TILE_SAT_EN selects saturating output conversion (default: wrap).
module systolic_tile
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_GUARD  = 8,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*BIT_WIDTH-1:0] west_in,
  input  logic [COLS*BIT_WIDTH-1:0] north_in,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [COLS*BIT_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]          out_row,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      done
);

  localparam int ACC_WIDTH = acc_width(BIT_WIDTH, ACC_GUARD);
  localparam int FLUSH_LEN = ROWS + COLS;
  localparam int CNT_W     = $clog2(FLUSH_LEN);

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_in_ready;
  logic                        w_in_ready_next;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_accept;
  logic                        w_flush_end;
  logic                        w_out_hs;
  logic                        w_last_hs;
  logic [ROW_W-1:0]            w_next_row;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic [ROW_W-1:0]            r_out_row;
  logic [COLS*BIT_WIDTH-1:0]   r_out_data;
  logic                        r_done;
  logic [BIT_WIDTH-1:0]        r_obuf [ROWS][COLS];

  logic signed [BIT_WIDTH-1:0] w_a_edge [ROWS];
  logic signed [BIT_WIDTH-1:0] w_b_edge [COLS];
  logic signed [BIT_WIDTH-1:0] w_a      [ROWS][COLS];
  logic signed [BIT_WIDTH-1:0] w_b      [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] w_acc    [ROWS][COLS];

  function automatic logic [BIT_WIDTH-1:0] to_out(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] v_sum;
    logic signed [ACC_WIDTH-1:0] v_sh;
    v_sum = acc + ACC_WIDTH'(round_const(FRAC_WIDTH));
    v_sh  = v_sum >>> FRAC_WIDTH;
`ifdef SYSTOLIC_TILE_SAT_EN
    if (longint'(v_sh) > sat_max(BIT_WIDTH)) begin
      return BIT_WIDTH'(sat_max(BIT_WIDTH));
    end else if (longint'(v_sh) < sat_min(BIT_WIDTH)) begin
      return BIT_WIDTH'(sat_min(BIT_WIDTH));
    end else begin
      return BIT_WIDTH'(v_sh);
    end
`else
    return BIT_WIDTH'(v_sh);
`endif
  endfunction

  assign w_accept    = in_valid && r_in_ready;
  assign w_flush_end = (r_state == ST_FLUSH) && (r_cnt == CNT_W'(FLUSH_LEN - 1));
  assign w_out_hs    = (r_state == ST_DRAIN) && r_out_valid && out_ready;
  assign w_last_hs   = w_out_hs && r_out_last;
  assign w_next_row  = r_out_row + ROW_W'(1);

  // Next-state and registered in_ready decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = in_last ? ST_FLUSH : ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_accept && in_last) begin
          w_next = ST_FLUSH;
        end else begin
          w_next = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (w_flush_end) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (w_last_hs) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    w_in_ready_next = (w_next == ST_IDLE) || (w_next == ST_LOAD);
  end

  // State register, in_ready and flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_in_ready_next;
      r_cnt      <= (r_state == ST_FLUSH) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  // West edge: one capture register plus r skew stages; idle cycles inject zeros.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_west
    logic signed [BIT_WIDTH-1:0] r_dly [gr+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= gr; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_accept ? west_in[gr*BIT_WIDTH +: BIT_WIDTH] : '0;
        for (int i = 1; i <= gr; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_a_edge[gr] = r_dly[gr];
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_north
    logic signed [BIT_WIDTH-1:0] r_dly [gc+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= gc; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_accept ? north_in[gc*BIT_WIDTH +: BIT_WIDTH] : '0;
        for (int i = 1; i <= gc; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_b_edge[gc] = r_dly[gc];
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic signed [BIT_WIDTH-1:0] w_pa;
      logic signed [BIT_WIDTH-1:0] w_pb;
      if (gc == 0) begin : g_a_edge
        assign w_pa = w_a_edge[gr];
      end else begin : g_a_hop
        assign w_pa = w_a[gr][gc-1];
      end
      if (gr == 0) begin : g_b_edge
        assign w_pb = w_b_edge[gc];
      end else begin : g_b_hop
        assign w_pb = w_b[gr-1][gc];
      end
      systolic_pe #(
        .BIT_WIDTH(BIT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_clr(w_flush_end),
        .i_a  (w_pa),
        .i_b  (w_pb),
        .o_a  (w_a[gr][gc]),
        .o_b  (w_b[gr][gc]),
        .o_acc(w_acc[gr][gc])
      );
    end
  end

  // Output buffer snapshot taken as the accumulators clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) r_obuf[r][c] <= '0;
    end else if (w_flush_end) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) r_obuf[r][c] <= to_out(w_acc[r][c]);
    end
  end

  // Row 0 is presented straight from the accumulators; later rows from the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_row   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_hs;
      if (w_flush_end) begin
        r_out_valid <= 1'b1;
        r_out_row   <= '0;
        r_out_last  <= (ROWS == 1);
        for (int c = 0; c < COLS; c++)
          r_out_data[c*BIT_WIDTH +: BIT_WIDTH] <= to_out(w_acc[0][c]);
      end else if (w_out_hs) begin
        if (r_out_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_row   <= '0;
          r_out_data  <= '0;
        end else begin
          r_out_row  <= w_next_row;
          r_out_last <= (w_next_row == ROW_W'(ROWS - 1));
          for (int c = 0; c < COLS; c++)
            r_out_data[c*BIT_WIDTH +: BIT_WIDTH] <= r_obuf[w_next_row][c];
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_row   = r_out_row;
  assign out_data  = r_out_data;
  assign done      = r_done;

endmodule
